dac_tm_mc: RTL

Parametrised, multi-channel, tape-scanning binary-to-level converter. It is the successor to the single-channel 4-bit scanner in the DAC model. On a load request it snapshots CHANNELS input codes of WIDTH bits each, then scans each code serially, MSB first, one bit per clock. Each channel's scaled integer output level is registered and published when that channel's scan finishes, followed by a one-cycle completion pulse.

---
 rtl/dac_tm_mc.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/dac_tm_mc.sv
// dac_tm_mc -- multi-channel, tape-scanning binary-to-level converter.
//
// A load request snapshots CHANNELS codes of WIDTH bits each. Each code is
// then scanned serially, MSB first, one bit per clock, into an accumulator.
// When a channel's scan finishes, its code and its scaled level (code * STEP,
// truncated to OUT_W bits) are registered. The channels are published one
// after another, and a one-cycle done pulse follows the last channel.
//
// Handshake: load is a start request. It is accepted only on an edge where the
// block is idle (busy=0). A load seen while busy=1 is dropped, not queued.
//
// Optional build macro DAC_TM_CONT_EN: when it is defined, an idle block also
// starts a conversion whenever `in` differs from the last accepted snapshot.
// With that macro undefined, only load starts a conversion.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (aborts any conversion)
//   in         CHANNELS*WIDTH input codes, channel c = in[c*WIDTH +: WIDTH]
//   load       start request, sampled only while idle
//   busy       high in every state except IDLE
//   done       one-cycle pulse while in DONE
//   code       last converted code per channel, same packing as in
//   out        last level per channel, out[c*OUT_W +: OUT_W]
//   ch_valid   bit c set once channel c holds a result of the current/last run
//   dbg_state  FSM state (0 IDLE, 1 SCAN, 2 STORE, 3 DONE) for checkers
module dac_tm_mc #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int STEP     = 75,
  parameter int OUT_W    = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CHANNELS*WIDTH-1:0]   in,
  input  logic                        load,
  output logic                        busy,
  output logic                        done,
  output logic [CHANNELS*WIDTH-1:0]   code,
  output logic [CHANNELS*OUT_W-1:0]   out,
  output logic [CHANNELS-1:0]         ch_valid,
  output logic [1:0]                  dbg_state
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    STORE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                      state;
  logic [CHANNELS*WIDTH-1:0]   snapshot;
  logic [WIDTH-1:0]            acc;
  logic [CW-1:0]               ch_idx;
  logic [BW-1:0]               bit_idx;

  logic                        snap_bit;
  logic [WIDTH-1:0]            acc_next;
  logic [OUT_W-1:0]            level;
  logic                        start;

  assign dbg_state = state;

  // Bit under the tape head: channel ch_idx, scanned from its MSB downwards.
  always_comb begin
    snap_bit = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int b = 0; b < WIDTH; b++) begin
        if (CW'(c) == ch_idx && BW'(b) == bit_idx) begin
          snap_bit = snapshot[c*WIDTH + WIDTH-1-b];
        end
      end
    end
  end

  // Shift the new bit in at the LSB; a one-bit code is just the bit itself.
  generate
    if (WIDTH > 1) begin : g_shift
      assign acc_next = {acc[WIDTH-2:0], snap_bit};
    end else begin : g_single
      assign acc_next = snap_bit;
    end
  endgenerate

  // Both operands are cast to OUT_W bits, so the product keeps only the low
  // OUT_W bits of code * STEP.
  assign level = OUT_W'(acc) * OUT_W'(STEP);

`ifdef DAC_TM_CONT_EN
  // snapshot only changes on acceptance, so it is the copy of the last
  // accepted input. It resets to 0, so in=0 after reset does not start a run.
  assign start = load | (in != snapshot);
`else
  assign start = load;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      snapshot <= '0;
      acc      <= '0;
      ch_idx   <= '0;
      bit_idx  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      code     <= '0;
      out      <= '0;
      ch_valid <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            snapshot <= in;
            ch_idx   <= '0;
            bit_idx  <= '0;
            acc      <= '0;
            ch_valid <= '0;
            busy     <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          acc <= acc_next;
          if (bit_idx == BW'(WIDTH-1)) begin
            state <= STORE;
          end else begin
            bit_idx <= bit_idx + BW'(1);
          end
        end
        STORE: begin
          for (int c = 0; c < CHANNELS; c++) begin
            if (CW'(c) == ch_idx) begin
              code[c*WIDTH +: WIDTH] <= acc;
              out[c*OUT_W +: OUT_W]  <= level;
              ch_valid[c]            <= 1'b1;
            end
          end
          if (ch_idx == CW'(CHANNELS-1)) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            ch_idx  <= ch_idx + CW'(1);
            bit_idx <= '0;
            acc     <= '0;
            state   <= SCAN;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
